// File: rtl/start_cloud_hps_system_pio_sequencer_if.sv
// start_cloud_hps_system_pio_sequencer_if: CSR slave port and PIO master port of the sequencer.
interface start_cloud_hps_system_pio_sequencer_if;
   logic [3:0]  csr_address;
   logic        csr_chipselect;
   logic        csr_write_n;
   logic [31:0] csr_writedata;
   logic [31:0] csr_readdata;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;
   modport master (
      output csr_address, csr_chipselect, csr_write_n, csr_writedata,
      input  csr_readdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
   );
   modport slave (
      input  csr_address, csr_chipselect, csr_write_n, csr_writedata,
      output csr_readdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
   );
endinterface

// File: rtl/start_cloud_hps_system_pio_sequencer.sv
// start_cloud_hps_system_pio_sequencer: replays up to DEPTH CSR-programmed patterns
// onto the PIO Avalon-MM slave, one write strobe every PERIOD clocks.
module start_cloud_hps_system_pio_sequencer #(
   parameter int DATA_WIDTH   = 10,
   parameter int DEPTH        = 8,
   parameter int PERIOD_WIDTH = 24
) (
   input  logic clk,
   input  logic reset_n,
   start_cloud_hps_system_pio_sequencer_if.slave bus,
   output logic irq
);
   typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
   state_t                  state_q, state_d;
   logic [2:0]              idx_q, idx_d, nxt_idx;
   logic [3:0]              len_q, eff_len;
   logic [PERIOD_WIDTH-1:0] hold_q, hold_d, period_q, eff_period;
   logic [3:0]              length_q;
   logic [DATA_WIDTH-1:0]   pat_q [DEPTH];
   logic                    loop_q, irq_en_q, done_q, done_d;
   logic                    pio_cs_q, pio_wn_q;
   logic [31:0]             pio_wd_q;
   logic                    wr, wr_ctrl, busy, start, abort, adv, last, go, pat_sel;

   assign wr         = bus.csr_chipselect & ~bus.csr_write_n;
   assign wr_ctrl    = wr && bus.csr_address == 4'd0;
   assign busy       = state_q != IDLE;
   assign start      = wr_ctrl & bus.csr_writedata[0] & ~busy;
   assign abort      = wr_ctrl & ~bus.csr_writedata[0] & busy;
   assign eff_period = period_q == '0 ? PERIOD_WIDTH'(1) : period_q;
   assign eff_len    = length_q == 4'd0 ? 4'd1 : length_q > 4'(DEPTH) ? 4'(DEPTH) : length_q;
   assign adv        = (state_q == WRITE && eff_period == PERIOD_WIDTH'(1)) || (state_q == HOLD && hold_q == '0);
   assign last       = {1'b0, idx_q} >= len_q - 4'd1;
   assign nxt_idx    = last ? 3'd0 : idx_q + 3'd1;
   // Abort wins over a step advance landing on the same edge, so no new strobe follows it.
   assign go         = start | (adv & (~last | loop_q) & ~abort);
   assign idx_d      = start ? 3'd0 : go ? nxt_idx : idx_q;
   assign state_d    = go ? WRITE : (abort | adv) ? IDLE : state_q == WRITE ? HOLD : state_q;
   assign hold_d     = state_q == WRITE ? eff_period - PERIOD_WIDTH'(2) : state_q == HOLD ? hold_q - PERIOD_WIDTH'(1) : hold_q;
   // A done set beats a same-cycle W1C clear.
   assign done_d     = (adv & last & ~loop_q & ~abort) | (done_q & ~(wr && bus.csr_address == 4'd1 && bus.csr_writedata[1]));
   assign pat_sel    = bus.csr_address[3] && 32'(bus.csr_address[2:0]) < DEPTH;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         hold_q   <= '0;
         done_q   <= 1'b0;
         pio_cs_q <= 1'b0;
         pio_wn_q <= 1'b1;
         pio_wd_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= start ? eff_len : len_q;
         hold_q   <= hold_d;
         done_q   <= done_d;
         pio_cs_q <= go;
         pio_wn_q <= ~go;
         pio_wd_q <= go ? 32'(pat_q[idx_d]) : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loop_q   <= 1'b0;
         irq_en_q <= 1'b0;
         period_q <= '0;
         length_q <= '0;
         for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
      end else if (wr) begin
         if (bus.csr_address == 4'd0) begin
            loop_q   <= bus.csr_writedata[1];
            irq_en_q <= bus.csr_writedata[2];
         end
         if (bus.csr_address == 4'd2) period_q <= bus.csr_writedata[PERIOD_WIDTH-1:0];
         if (bus.csr_address == 4'd3) length_q <= bus.csr_writedata[3:0];
         for (int i = 0; i < DEPTH; i++)
            if (bus.csr_address == 4'(8 + i)) pat_q[i] <= bus.csr_writedata[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      bus.csr_readdata = bus.csr_address == 4'd0 ? {29'd0, busy, loop_q, irq_en_q} :
                         bus.csr_address == 4'd1 ? {21'd0, idx_q, 6'd0, done_q, busy} :
                         bus.csr_address == 4'd2 ? 32'(period_q) :
                         bus.csr_address == 4'd3 ? {28'd0, length_q} :
                         pat_sel ? 32'(pat_q[bus.csr_address[2:0]]) : 32'd0;
   end

   assign bus.pio_address    = 2'd0;
   assign bus.pio_chipselect = pio_cs_q;
   assign bus.pio_write_n    = pio_wn_q;
   assign bus.pio_writedata  = pio_wd_q;
   assign irq                = done_q & irq_en_q;
endmodule

// File: tb/tb_start_cloud_hps_system_pio_sequencer.sv
// tb_start_cloud_hps_system_pio_sequencer: directed CSR programming with a strobe
// recorder; every expected value is hand-computed from the register map and timing.
module tb_start_cloud_hps_system_pio_sequencer;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic irq;
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int sq_cyc[$];
   logic [31:0] sq_dat[$];

   start_cloud_hps_system_pio_sequencer_if bus();
   start_cloud_hps_system_pio_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Record each PIO strobe with the cycle it was on the bus.
   always @(negedge clk)
      if (reset_n && bus.pio_chipselect && !bus.pio_write_n) begin
         sq_cyc.push_back(cyc);
         sq_dat.push_back(bus.pio_writedata);
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus.csr_address    = a;
      bus.csr_writedata  = d;
      bus.csr_chipselect = 1'b1;
      bus.csr_write_n    = 1'b0;
      @(negedge clk);
      bus.csr_chipselect = 1'b0;
      bus.csr_write_n    = 1'b1;
   endtask

   task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
      bus.csr_address = a;
      #1;
      check(tag, bus.csr_readdata, exp);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr_q();
      sq_cyc.delete();
      sq_dat.delete();
   endtask

   initial begin
      bus.csr_address    = '0;
      bus.csr_chipselect = 1'b0;
      bus.csr_write_n    = 1'b1;
      bus.csr_writedata  = '0;
      wait_n(2);
      check("rst_cs", 32'(bus.pio_chipselect), 0);
      check("rst_wn", 32'(bus.pio_write_n), 1);
      check("rst_wd", bus.pio_writedata, 0);
      check("rst_irq", 32'(irq), 0);
      rd("rst_status", 4'd1, 0);
      rd("rst_ctrl", 4'd0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // one-shot, PERIOD=4, LENGTH=3, irq enabled
      wr(4'd8, 32'h001); wr(4'd9, 32'h002); wr(4'd10, 32'h3FF);
      wr(4'd2, 4); wr(4'd3, 3);
      rd("period_rb", 4'd2, 4);
      rd("unmapped_rd", 4'd5, 0);
      clr_q();
      wr(4'd0, 32'h5);
      check("os_addr", 32'(bus.pio_address), 0);
      rd("os_busy", 4'd1, 32'h001);
      wait_n(11);
      check("os_irq_early", 32'(irq), 0);
      wait_n(1);
      check("os_irq", 32'(irq), 1);
      check("os_count", sq_dat.size(), 3);
      check("os_d0", sq_dat[0], 32'h001);
      check("os_d1", sq_dat[1], 32'h002);
      check("os_d2", sq_dat[2], 32'h3FF);
      check("os_gap01", sq_cyc[1] - sq_cyc[0], 4);
      check("os_gap12", sq_cyc[2] - sq_cyc[1], 4);
      rd("os_status", 4'd1, 32'h202);
      rd("os_ctrl", 4'd0, 32'h1);
      wr(4'd1, 32'h2);
      check("os_irq_clr", 32'(irq), 0);
      rd("os_status_clr", 4'd1, 32'h200);

      // loop, PERIOD=0 -> 1, LENGTH=2, then abort after 10 strobes
      wr(4'd2, 0); wr(4'd3, 2);
      clr_q();
      wr(4'd0, 32'h3);
      wait_n(9);
      wr(4'd0, 32'h0);
      wait_n(5);
      check("lp_count", sq_dat.size(), 10);
      check("lp_d0", sq_dat[0], 32'h001);
      check("lp_d1", sq_dat[1], 32'h002);
      check("lp_d8", sq_dat[8], 32'h001);
      check("lp_d9", sq_dat[9], 32'h002);
      check("lp_span", sq_cyc[9] - sq_cyc[0], 9);
      rd("lp_status", 4'd1, 32'h100);

      // LENGTH=12 saturates to 8, run=1 while busy ignored
      wr(4'd11, 32'h008); wr(4'd12, 32'h010); wr(4'd13, 32'h020);
      wr(4'd14, 32'h040); wr(4'd15, 32'h080);
      wr(4'd2, 2); wr(4'd3, 12);
      rd("len_rb", 4'd3, 12);
      clr_q();
      wr(4'd0, 32'h1);
      wait_n(3);
      wr(4'd0, 32'h1);
      wait_n(20);
      check("sat_count", sq_dat.size(), 8);
      check("sat_d3", sq_dat[3], 32'h008);
      check("sat_d7", sq_dat[7], 32'h080);
      check("sat_span", sq_cyc[7] - sq_cyc[0], 14);
      rd("sat_status", 4'd1, 32'h702);
      wr(4'd1, 32'h2);

      // LENGTH=0 -> single step
      wr(4'd3, 0);
      clr_q();
      wr(4'd0, 32'h1);
      wait_n(6);
      check("one_count", sq_dat.size(), 1);
      check("one_d0", sq_dat[0], 32'h001);
      rd("one_status", 4'd1, 32'h002);
      wr(4'd1, 32'h2);

      // pattern and period rewritten during HOLD of step 0
      wr(4'd2, 4); wr(4'd3, 3);
      clr_q();
      wr(4'd0, 32'h1);
      wait_n(1);
      wr(4'd9, 32'h155);
      wr(4'd2, 2);
      wait_n(12);
      check("mid_count", sq_dat.size(), 3);
      check("mid_d1", sq_dat[1], 32'h155);
      check("mid_d2", sq_dat[2], 32'h3FF);
      check("mid_gap01", sq_cyc[1] - sq_cyc[0], 4);
      check("mid_gap12", sq_cyc[2] - sq_cyc[1], 2);
      rd("mid_status", 4'd1, 32'h202);
      wr(4'd1, 32'h2);

      // done set and W1C on the same edge
      wr(4'd3, 0); wr(4'd2, 2);
      wr(4'd0, 32'h5);
      wait_n(1);
      wr(4'd1, 32'h2);
      rd("sim_status", 4'd1, 32'h002);
      check("sim_irq", 32'(irq), 1);

      // asynchronous reset in the middle of HOLD
      wr(4'd2, 8); wr(4'd3, 1);
      wr(4'd0, 32'h5);
      wait_n(3);
      rd("pre_rst_status", 4'd1, 32'h003);
      check("pre_rst_irq", 32'(irq), 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_cs", 32'(bus.pio_chipselect), 0);
      check("arst_wn", 32'(bus.pio_write_n), 1);
      check("arst_wd", bus.pio_writedata, 0);
      check("arst_irq", 32'(irq), 0);
      rd("arst_status", 4'd1, 0);
      rd("arst_pat0", 4'd8, 0);
      rd("arst_period", 4'd2, 0);
      rd("arst_ctrl", 4'd0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_n(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/start_cloud_hps_system_pio_sequencer.md
# start_cloud_hps_system_pio_sequencer

Autonomous pattern sequencer for the 10-bit output PIO (LED/switch-indicator port) in the HPS system. The HPS programs up to eight patterns, a step period and a step count through a small Avalon-MM control slave. The block then drives the PIO's Avalon-MM slave as a master, writing one pattern per step with no further software involvement. It sits between the HPS lightweight bridge and the PIO `s1` port. It is the PIO's only writer while the sequencer is in use.

## Interface
Parameters:
- DATA_WIDTH, 10, pattern width; matches PIO `out_port`.
- DEPTH, 8, number of pattern registers; power of two, max 8.
- PERIOD_WIDTH, 24, width of the step-period register.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- csr_address  in  4  control-slave word address.
- csr_chipselect  in  1  control-slave select.
- csr_write_n  in  1  control-slave write strobe, active low.
- csr_writedata  in  32  control-slave write data.
- csr_readdata  out  32  control-slave read data; combinational, zero wait states.
- pio_address  out  2  to PIO `address`; always 0.
- pio_chipselect  out  1  to PIO `chipselect`.
- pio_write_n  out  1  to PIO `write_n`, active low.
- pio_writedata  out  32  to PIO `writedata`; bits [31:DATA_WIDTH] are always 0.
- irq  out  1  level interrupt, equal to `done & irq_en`.

## Operation
CSR map (word addresses). A write occurs when `csr_chipselect & ~csr_write_n`.
- 0 CTRL (R/W):
  - bit0 `run`: write 1 starts a sequence; write 0 aborts one.
  - bit1 `loop`.
  - bit2 `irq_en`.
  - Reads return `{busy, loop, irq_en}` in bits [2:0].
- 1 STATUS (RO except W1C):
  - bit0 `busy`.
  - bit1 `done`: sticky; write 1 to clear.
  - bits[10:8] current index.
- 2 PERIOD (R/W): bits[PERIOD_WIDTH-1:0], the step interval in clocks. The value 0 is treated as 1.
- 3 LENGTH (R/W): bits[3:0], the step count. The value 0 is treated as 1; values above DEPTH saturate to DEPTH.
- 8..8+DEPTH-1 PATTERN[i] (R/W): bits[DATA_WIDTH-1:0].
- All other addresses read 0; writes to them are ignored.

State machine IDLE / WRITE / HOLD:
- IDLE: a CTRL write with run=1 sets idx=0, latches the effective LENGTH into `len_q` and goes to WRITE.
- WRITE (exactly one cycle):
  - Drives `pio_chipselect=1`, `pio_write_n=0`, `pio_address=0`, `pio_writedata={0, PATTERN[idx]}`.
  - Loads `hold_cnt = eff_period-2`.
  - If `eff_period==1`, skips HOLD and applies the step-advance rule immediately. Otherwise goes to HOLD.
- HOLD: decrements `hold_cnt`. When `hold_cnt==0`, applies the step-advance rule.
- Step-advance rule:
  - If `idx < len_q-1`: idx+1, go to WRITE.
  - Else if `loop`: idx=0, go to WRITE.
  - Else: set `done`, go to IDLE.
- `busy` = state != IDLE.
- When the PIO bus is idle: `pio_chipselect=0`, `pio_write_n=1`, `pio_writedata=0`.

Boundary and simultaneous events:
- run=1 written while busy: ignored; no restart.
- run=0 written while busy: next state is IDLE and `done` is not set. A strobe already on the bus that cycle completes.
- PATTERN writes during a run take effect at the next WRITE of that index. PERIOD is sampled at each WRITE. LENGTH is latched only at start.
- `done` set and W1C clear in the same cycle: set wins.
- Loop mode never sets `done`.

## Timing
- Reset values:
  - Outputs: `pio_write_n=1`; all other outputs 0.
  - Registers: PATTERN, PERIOD, LENGTH, CTRL and STATUS are all 0.
  - State is IDLE.
- Start latency: for a CTRL write at clock edge t, the first PIO strobe is high during the cycle after edge t and is sampled by the PIO at edge t+1.
- Consecutive strobes are exactly `eff_period` clocks apart. This includes the wrap from the last pattern back to the first in loop mode.
- Each strobe lasts exactly one clock.
- One-shot: `done` and `busy=0` are visible in the cycle after the final HOLD cycle, i.e. `eff_period` clocks after the last strobe.
- `irq` follows `done` combinationally through a register-AND; it carries no additional delay.

## Test plan
- Reset: assert reset_n=0 mid-HOLD → all outputs reach their reset values immediately (asynchronously); STATUS reads 0; PATTERN[0] reads 0.
- One-shot: PATTERN[0..2]=0x001,0x002,0x3FF, PERIOD=4, LENGTH=3, CTRL=0x5 → exactly three strobes at 4-clock spacing with writedata 0x001, 0x002, 0x3FF; `done=1` and `irq=1` 4 clocks after the third strobe; W1C STATUS=0x2 → irq=0.
- Loop with PERIOD=0 (treated as 1), LENGTH=2, CTRL=0x3 → back-to-back strobes alternating PATTERN[0]/PATTERN[1] every clock; after 10 strobes write CTRL=0 → no further strobes; `done=0`.
- LENGTH=12 → saturates to 8 steps; LENGTH=0 → single step; a CTRL run=1 write while busy → strobe sequence unaffected.
- PATTERN[1] rewritten to 0x155 during HOLD of step 0 → step 1 strobe carries 0x155; PERIOD changed mid-run → new spacing applies from the next WRITE.
- Simultaneous `done` set and W1C clear in one cycle → `done` reads 1.
